// File: rtl/brake_light_driver.sv
// Brake/tail LED PWM output stage: dim tail, staged brake, release hold, tipover hazard blink, thermal derate.
// Latency: input -> state 2 edges, input -> LED 3 edges (PWM phase permitting); no backpressure, always accepts.
module brake_light_driver #(
  parameter int PWM_BITS          = 8,
  parameter int DIM_DUTY          = 32,
  parameter int FULL_DUTY         = 256,
  parameter int HOLD_CYCLES       = 500000,
  parameter int BLINK_HALF_CYCLES = 1000000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       light_en,
  input  logic [1:0] brake_code,
  input  logic       tipover,
  input  logic       temp_warning,
  output logic       led_stage1,
  output logic       led_stage2,
  output logic [2:0] state_o,
  output logic       brake_active,
  output logic       hazard_active
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STAGE1 = 3'd1,
    STAGE2 = 3'd2,
    HOLD   = 3'd3,
    HAZARD = 3'd4
  } state_t;

  localparam int DW = PWM_BITS + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [DW-1:0] DIM_D      = DW'(DIM_DUTY);
  localparam logic [DW-1:0] FULL_D     = DW'(FULL_DUTY);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  logic                light_en_r;
  logic [1:0]          code_r;
  logic                tip_r;
  logic                temp_r;
  state_t              state;
  state_t              nxt;
  logic                last_stage2;
  logic [HW-1:0]       hold_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                blink_on;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       base_s1;
  logic [DW-1:0]       base_s2;
  logic [DW-1:0]       duty_s1;
  logic [DW-1:0]       duty_s2;

  assign state_o = state;

  // Nonzero brake code is checked before the HOLD expiry so a reasserted code beats IDLE.
  always_comb begin
    nxt = state;
    if (!light_en_r) begin
      nxt = IDLE;
    end else if (tip_r) begin
      nxt = HAZARD;
    end else if (code_r == 2'b01) begin
      nxt = STAGE1;
    end else if (code_r[1]) begin
      nxt = STAGE2;
    end else begin
      case (state)
        STAGE1, STAGE2: nxt = HOLD;
        HOLD:           nxt = (hold_cnt == HOLD_LAST) ? IDLE : HOLD;
        default:        nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    base_s1 = '0;
    base_s2 = '0;
    case (state)
      IDLE:   base_s1 = DIM_D;
      STAGE1: base_s1 = FULL_D;
      STAGE2: begin
        base_s1 = FULL_D;
        base_s2 = FULL_D;
      end
      HOLD: begin
        base_s1 = FULL_D;
        base_s2 = last_stage2 ? FULL_D : '0;
      end
      HAZARD: begin
        base_s1 = blink_on ? FULL_D : '0;
        base_s2 = blink_on ? FULL_D : '0;
      end
      default: begin
        base_s1 = '0;
        base_s2 = '0;
      end
    endcase
    duty_s1 = temp_r ? (base_s1 >> 1) : base_s1;
    duty_s2 = temp_r ? (base_s2 >> 1) : base_s2;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      light_en_r    <= 1'b0;
      code_r        <= 2'b00;
      tip_r         <= 1'b0;
      temp_r        <= 1'b0;
      state         <= IDLE;
      last_stage2   <= 1'b0;
      hold_cnt      <= '0;
      blink_cnt     <= '0;
      blink_on      <= 1'b0;
      pwm_cnt       <= '0;
      led_stage1    <= 1'b0;
      led_stage2    <= 1'b0;
      brake_active  <= 1'b0;
      hazard_active <= 1'b0;
    end else begin
      light_en_r    <= light_en;
      code_r        <= brake_code;
      tip_r         <= tipover;
      temp_r        <= temp_warning;
      state         <= nxt;
      pwm_cnt       <= pwm_cnt + 1'b1;
      brake_active  <= (nxt == STAGE1) || (nxt == STAGE2) || (nxt == HOLD);
      hazard_active <= (nxt == HAZARD);

      if (nxt == HOLD && state != HOLD) begin
        hold_cnt    <= '0;
        last_stage2 <= (state == STAGE2);
      end else if (nxt == HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end

      // Blink restarts in the on phase at every HAZARD entry.
      if (nxt == HAZARD && state != HAZARD) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (nxt == HAZARD) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink_on  <= 1'b0;
      end

      led_stage1 <= light_en_r && ({1'b0, pwm_cnt} < duty_s1);
      led_stage2 <= light_en_r && ({1'b0, pwm_cnt} < duty_s2);
    end
  end

endmodule

// File: tb/tb_brake_light_driver.sv
// Directed bench for brake_light_driver with short hold/blink timing.
module tb_brake_light_driver;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       light_en;
  logic [1:0] brake_code;
  logic       tipover;
  logic       temp_warning;
  logic       led_stage1;
  logic       led_stage2;
  logic [2:0] state_o;
  logic       brake_active;
  logic       hazard_active;

  int n_cmp = 0;
  int n_bad = 0;

  brake_light_driver #(
    .PWM_BITS(8),
    .DIM_DUTY(32),
    .FULL_DUTY(256),
    .HOLD_CYCLES(20),
    .BLINK_HALF_CYCLES(10)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .light_en(light_en),
    .brake_code(brake_code),
    .tipover(tipover),
    .temp_warning(temp_warning),
    .led_stage1(led_stage1),
    .led_stage2(led_stage2),
    .state_o(state_o),
    .brake_active(brake_active),
    .hazard_active(hazard_active)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic measure(input int n, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    repeat (n) begin
      @(negedge sys_clk);
      c1 += int'(led_stage1);
      c2 += int'(led_stage2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; light_en = 1'b0; brake_code = 2'b00; tipover = 1'b0; temp_warning = 1'b0;
    tick(3);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if ({led_stage1, led_stage2} !== 2'b00) begin n_bad++; $display("FAIL reset_leds: got %b want 00", {led_stage1, led_stage2}); end
    n_cmp++; if ({brake_active, hazard_active} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {brake_active, hazard_active}); end
    rst = 1'b0; light_en = 1'b1;
    tick(4);
  endtask

  task automatic test_idle_dim;
    int c1, c2;
    measure(512, c1, c2);
    n_cmp++; if (c1 != 64) begin n_bad++; $display("FAIL idle_dim_s1: got %0d want 64", c1); end
    n_cmp++; if (c2 != 0) begin n_bad++; $display("FAIL idle_dim_s2: got %0d want 0", c2); end
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL idle_state: got %0d want 0", state_o); end
  endtask

  task automatic test_stages;
    int c1, c2;
    brake_code = 2'b01;
    tick(1);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL stage1_early: got %0d want 0", state_o); end
    tick(1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL stage1_state: got %0d want 1", state_o); end
    n_cmp++; if (brake_active !== 1'b1) begin n_bad++; $display("FAIL stage1_brake_active: got %b want 1", brake_active); end
    tick(1);
    measure(256, c1, c2);
    n_cmp++; if (c1 != 256 || c2 != 0) begin n_bad++; $display("FAIL stage1_leds: got %0d/%0d want 256/0", c1, c2); end
    brake_code = 2'b11;
    tick(2);
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL stage2_state: got %0d want 2", state_o); end
    tick(1);
    measure(256, c1, c2);
    n_cmp++; if (c1 != 256 || c2 != 256) begin n_bad++; $display("FAIL stage2_leds: got %0d/%0d want 256/256", c1, c2); end
  endtask

  task automatic test_hold;
    int in_hold, lit, bad;
    brake_code = 2'b00;
    tick(2);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL hold_entry: got %0d want 3", state_o); end
    in_hold = 1;
    lit = int'(led_stage1 & led_stage2);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (state_o === 3'd3) begin
        in_hold++;
        lit += int'(led_stage1 & led_stage2);
      end
    end
    n_cmp++; if (in_hold != 20) begin n_bad++; $display("FAIL hold_length: got %0d want 20", in_hold); end
    n_cmp++; if (lit != 20) begin n_bad++; $display("FAIL hold_leds_on: got %0d want 20", lit); end
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL hold_expiry: got %0d want 0", state_o); end

    brake_code = 2'b11;
    tick(4);
    brake_code = 2'b00;
    tick(2);
    bad = (state_o === 3'd3) ? 0 : 1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (state_o !== 3'd3) bad++;
    end
    brake_code = 2'b01;
    tick(1);
    if (state_o !== 3'd3) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_reapply_stay: got %0d non-hold samples want 0", bad); end
    tick(1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL hold_reapply_stage: got %0d want 1", state_o); end
  endtask

  task automatic test_hazard;
    int err1, err2;
    logic exp;
    brake_code = 2'b11; tipover = 1'b1;
    tick(2);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL hazard_state: got %0d want 4", state_o); end
    n_cmp++; if ({brake_active, hazard_active} !== 2'b01) begin n_bad++; $display("FAIL hazard_flags: got %b want 01", {brake_active, hazard_active}); end
    err1 = 0; err2 = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      exp = ((k / 10) % 2) == 0;
      if (led_stage1 !== exp) err1++;
      if (led_stage2 !== exp) err2++;
    end
    n_cmp++; if (err1 != 0) begin n_bad++; $display("FAIL hazard_blink_s1: got %0d wrong samples want 0", err1); end
    n_cmp++; if (err2 != 0) begin n_bad++; $display("FAIL hazard_blink_s2: got %0d wrong samples want 0", err2); end
    tipover = 1'b0; brake_code = 2'b01;
    tick(1);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL hazard_exit_early: got %0d want 4", state_o); end
    tick(1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL hazard_exit_stage1: got %0d want 1", state_o); end
  endtask

  task automatic test_derate;
    int c1, c2;
    temp_warning = 1'b1; brake_code = 2'b11;
    tick(4);
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL derate_state: got %0d want 2", state_o); end
    measure(256, c1, c2);
    n_cmp++; if (c1 != 128 || c2 != 128) begin n_bad++; $display("FAIL derate_stage2: got %0d/%0d want 128/128", c1, c2); end
    brake_code = 2'b00;
    tick(30);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL derate_idle_state: got %0d want 0", state_o); end
    measure(256, c1, c2);
    n_cmp++; if (c1 != 16 || c2 != 0) begin n_bad++; $display("FAIL derate_idle: got %0d/%0d want 16/0", c1, c2); end
    temp_warning = 1'b0;
  endtask

  task automatic test_disable_reset;
    int c1, c2;
    tipover = 1'b1;
    tick(2);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL dis_hazard_state: got %0d want 4", state_o); end
    tick(5);
    light_en = 1'b0;
    tick(2);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL dis_state: got %0d want 0", state_o); end
    n_cmp++; if ({led_stage1, led_stage2, hazard_active} !== 3'b000) begin n_bad++; $display("FAIL dis_outputs: got %b want 000", {led_stage1, led_stage2, hazard_active}); end
    measure(20, c1, c2);
    n_cmp++; if (c1 != 0 || c2 != 0) begin n_bad++; $display("FAIL dis_leds_held_off: got %0d/%0d want 0/0", c1, c2); end
    light_en = 1'b1; tipover = 1'b0; brake_code = 2'b11;
    tick(4);
    brake_code = 2'b00;
    tick(2);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL rst_pre_hold: got %0d want 3", state_o); end
    tick(3);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_mid_state: got %0d want 0", state_o); end
    n_cmp++; if ({led_stage1, led_stage2, brake_active, hazard_active} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_outputs: got %b want 0000", {led_stage1, led_stage2, brake_active, hazard_active}); end
    rst = 1'b0;
    tick(3);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_after_state: got %0d want 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_idle_dim();
    test_stages();
    test_hold();
    test_hazard();
    test_derate();
    test_disable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
